// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: round-robin or fixed port-0 priority, locked bursts, tagged read return.
// Optional statistics counters are built when DMEM_ARB_STATS_EN is defined.
module dmem_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned MAX_BURST  = 8,
    parameter int unsigned FIXED_PRIO = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0,
    input  logic              lock0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [2:0]        op0,
    input  logic              we0,
    input  logic              req1,
    input  logic              lock1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    input  logic [2:0]        op1,
    input  logic              we1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic [2:0]        mem_op,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_dout,
`ifdef DMEM_ARB_STATS_EN
    input  logic              stat_clr,
    output logic [31:0]       stat_beats0,
    output logic [31:0]       stat_beats1,
    output logic [31:0]       stat_wait1,
`endif
    output logic [1:0]        owner
);

    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W:0] MAX_B = (CNT_W + 1)'(MAX_BURST);
    localparam logic [CNT_W:0] ONE_B = (CNT_W + 1)'(1);

    // State encoding doubles as the debug owner code.
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_OWN0 = 2'b01;
    localparam logic [1:0] ST_OWN1 = 2'b10;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] r_burst;
    logic [CNT_W-1:0] w_burst_nxt;
    logic [CNT_W:0]   w_burst_inc;
    logic             r_last;
    logic             w_last_nxt;
    logic             w_beat;
    logic             w_sel1;
    logic             w_we_sel;
    logic             w_lock_sel;
    logic             w_keep;
    logic             w_win1;
    logic             r_rv;
    logic             r_rtag;

    assign gnt0   = (r_state == ST_OWN0) & req0;
    assign gnt1   = (r_state == ST_OWN1) & req1;
    assign w_beat = gnt0 | gnt1;
    assign w_sel1 = (r_state == ST_OWN1);
    assign owner  = r_state;

    assign w_last_nxt  = w_beat ? gnt1 : r_last;
    assign w_win1      = (FIXED_PRIO != 0) ? 1'b0 : ~w_last_nxt;
    assign w_burst_inc = {1'b0, r_burst} + ONE_B;
    assign w_lock_sel  = w_sel1 ? lock1 : lock0;
    assign w_keep      = w_beat & w_lock_sel & (w_burst_inc < MAX_B);

    always_comb begin
        w_state_nxt = ST_IDLE;
        w_burst_nxt = '0;
        if (w_keep) begin
            w_state_nxt = r_state;
            w_burst_nxt = w_burst_inc[CNT_W-1:0];
        end else if (req0 & req1) begin
            w_state_nxt = w_win1 ? ST_OWN1 : ST_OWN0;
        end else if (req0) begin
            w_state_nxt = ST_OWN0;
        end else if (req1) begin
            w_state_nxt = ST_OWN1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_burst <= '0;
            r_last  <= 1'b1;
            r_rv    <= 1'b0;
            r_rtag  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_burst <= w_burst_nxt;
            r_last  <= w_last_nxt;
            r_rv    <= mem_re;
            r_rtag  <= w_sel1;
        end
    end

    assign mem_addr = w_sel1 ? addr1 : addr0;
    assign mem_din  = w_sel1 ? wdata1 : wdata0;
    assign mem_op   = w_sel1 ? op1 : op0;
    assign w_we_sel = w_sel1 ? we1 : we0;
    assign mem_we   = w_beat & w_we_sel;
    assign mem_re   = w_beat & ~w_we_sel;

    assign rvalid0 = r_rv & ~r_rtag;
    assign rvalid1 = r_rv & r_rtag;
    assign rdata0  = rvalid0 ? mem_dout : '0;
    assign rdata1  = rvalid1 ? mem_dout : '0;

`ifdef DMEM_ARB_STATS_EN
    // Saturating counters; a clear in the same cycle as an increment wins.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stat_beats0 <= '0;
            stat_beats1 <= '0;
            stat_wait1  <= '0;
        end else if (stat_clr) begin
            stat_beats0 <= '0;
            stat_beats1 <= '0;
            stat_wait1  <= '0;
        end else begin
            if (gnt0 && (stat_beats0 != 32'hFFFF_FFFF)) stat_beats0 <= stat_beats0 + 32'd1;
            if (gnt1 && (stat_beats1 != 32'hFFFF_FFFF)) stat_beats1 <= stat_beats1 + 32'd1;
            if (req1 && !gnt1 && (stat_wait1 != 32'hFFFF_FFFF)) stat_wait1 <= stat_wait1 + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus a randomized run against a transaction-level model.
module tb_dmem_arbiter;

    localparam int MAXB = 8;

    logic        clock, reset;
    logic        req0, lock0, we0, req1, lock1, we1;
    logic [31:0] addr0, wdata0, addr1, wdata1, mem_dout;
    logic [2:0]  op0, op1;
    logic        gnt0, gnt1, rvalid0, rvalid1, mem_we, mem_re;
    logic [31:0] rdata0, rdata1, mem_addr, mem_din;
    logic [2:0]  mem_op;
    logic [1:0]  owner;
    logic        f_gnt0, f_gnt1, f_rvalid0, f_rvalid1, f_mem_we, f_mem_re;
    logic [31:0] f_rdata0, f_rdata1, f_mem_addr, f_mem_din;
    logic [2:0]  f_mem_op;
    logic [1:0]  f_owner;
`ifdef DMEM_ARB_STATS_EN
    logic        stat_clr;
    logic [31:0] stat_beats0, stat_beats1, stat_wait1, f_sb0, f_sb1, f_sw1;
`endif

    int total = 0;
    int bad   = 0;

    dmem_arbiter dut (
        .clock(clock), .reset(reset),
        .req0(req0), .lock0(lock0), .addr0(addr0), .wdata0(wdata0), .op0(op0), .we0(we0),
        .req1(req1), .lock1(lock1), .addr1(addr1), .wdata1(wdata1), .op1(op1), .we1(we1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_op(mem_op), .mem_we(mem_we), .mem_re(mem_re), .mem_dout(mem_dout),
`ifdef DMEM_ARB_STATS_EN
        .stat_clr(stat_clr), .stat_beats0(stat_beats0), .stat_beats1(stat_beats1),
        .stat_wait1(stat_wait1),
`endif
        .owner(owner)
    );

    dmem_arbiter #(.MAX_BURST(1), .FIXED_PRIO(1)) dut_fp (
        .clock(clock), .reset(reset),
        .req0(req0), .lock0(lock0), .addr0(addr0), .wdata0(wdata0), .op0(op0), .we0(we0),
        .req1(req1), .lock1(lock1), .addr1(addr1), .wdata1(wdata1), .op1(op1), .we1(we1),
        .gnt0(f_gnt0), .gnt1(f_gnt1), .rvalid0(f_rvalid0), .rvalid1(f_rvalid1),
        .rdata0(f_rdata0), .rdata1(f_rdata1), .mem_addr(f_mem_addr), .mem_din(f_mem_din),
        .mem_op(f_mem_op), .mem_we(f_mem_we), .mem_re(f_mem_re), .mem_dout(mem_dout),
`ifdef DMEM_ARB_STATS_EN
        .stat_clr(stat_clr), .stat_beats0(f_sb0), .stat_beats1(f_sb1), .stat_wait1(f_sw1),
`endif
        .owner(f_owner)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic clear_inputs();
        req0 = 0; lock0 = 0; we0 = 0; addr0 = 0; wdata0 = 0; op0 = 0;
        req1 = 0; lock1 = 0; we1 = 0; addr1 = 0; wdata1 = 0; op1 = 0;
        mem_dout = 0;
`ifdef DMEM_ARB_STATS_EN
        stat_clr = 0;
`endif
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1;
        @(posedge clock); #1;
        reset = 0;
    endtask

    task automatic next_cycle();
        @(posedge clock); #1;
    endtask

    task automatic test_reset();
        logic [9:0] obs;
        do_reset();
        req0 = 1; we0 = 0; addr0 = 32'h40;
        next_cycle();                      // OWN0, beat issued
        next_cycle();                      // read in flight, rvalid0 visible
        mem_dout = 32'hA5A5_A5A5;
        total++;
        if (rvalid0 !== 1'b1) begin
            bad++; $display("FAIL pre_reset_rvalid0: got %b want 1", rvalid0);
        end
        #2 reset = 1;
        #1;
        obs = {gnt0, gnt1, rvalid0, rvalid1, |rdata0, |rdata1, mem_we, mem_re, owner};
        total++;
        if (obs !== 10'b0) begin
            bad++; $display("FAIL reset_outputs: got %b want 0000000000", obs);
        end
        clear_inputs();
        mem_dout = 32'hA5A5_A5A5;
        next_cycle();
        reset = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            total++;
            if ({rvalid0, rvalid1} !== 2'b00) begin
                bad++; $display("FAIL post_reset_rvalid[%0d]: got %b want 00", k, {rvalid0, rvalid1});
            end
            next_cycle();
        end
    endtask

    task automatic test_single_read();
        do_reset();
        req0 = 1; we0 = 0; addr0 = 32'h100; op0 = 3'b010;
        @(negedge clock);
        total++;
        if ({gnt0, mem_re} !== 2'b00) begin
            bad++; $display("FAIL read_latency_idle: got %b want 00", {gnt0, mem_re});
        end
        next_cycle();
        @(negedge clock);
        total++;
        if ({gnt0, gnt1, mem_re, mem_we, mem_addr, mem_op} !== {4'b1010, 32'h100, 3'b010}) begin
            bad++; $display("FAIL read_beat: got %b %h %h want 1010 100 2",
                            {gnt0, gnt1, mem_re, mem_we}, mem_addr, mem_op);
        end
        next_cycle();
        req0 = 0;
        mem_dout = 32'hDEAD_BEEF;
        @(negedge clock);
        total++;
        if ({rvalid0, rvalid1, rdata0, rdata1} !== {2'b10, 32'hDEAD_BEEF, 32'h0}) begin
            bad++; $display("FAIL read_return: got %b %h %h want 10 deadbeef 0",
                            {rvalid0, rvalid1}, rdata0, rdata1);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        req0 = 1; req1 = 1;
        @(negedge clock);
        total++;
        if ({gnt0, gnt1, f_gnt0, f_gnt1} !== 4'b0000) begin
            bad++; $display("FAIL rr_idle: got %b want 0000", {gnt0, gnt1, f_gnt0, f_gnt1});
        end
        for (int k = 0; k < 4; k++) begin
            logic [1:0] exp_g;
            next_cycle();
            @(negedge clock);
            exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
            total++;
            if ({gnt1, gnt0} !== exp_g) begin
                bad++; $display("FAIL rr_grant[%0d]: got %b want %b", k, {gnt1, gnt0}, exp_g);
            end
            total++;
            if ({f_gnt1, f_gnt0} !== 2'b01) begin
                bad++; $display("FAIL fixed_grant[%0d]: got %b want 01", k, {f_gnt1, f_gnt0});
            end
        end
    endtask

    task automatic test_lock_burst();
        do_reset();
        req1 = 1; lock1 = 1; we1 = 1; addr1 = 32'h300;
        next_cycle();
        req0 = 1;
        for (int k = 0; k <= MAXB; k++) begin
            logic [1:0] exp_g, exp_f;
            @(negedge clock);
            exp_g = (k < MAXB) ? 2'b10 : 2'b01;
            exp_f = (k == 0) ? 2'b10 : 2'b01;
            total++;
            if ({gnt1, gnt0} !== exp_g) begin
                bad++; $display("FAIL burst_beat[%0d]: got %b want %b", k, {gnt1, gnt0}, exp_g);
            end
            total++;
            if ({f_gnt1, f_gnt0} !== exp_f) begin
                bad++; $display("FAIL burst1_beat[%0d]: got %b want %b", k, {f_gnt1, f_gnt0}, exp_f);
            end
            next_cycle();
        end
    endtask

    task automatic test_write_then_read();
        do_reset();
        req1 = 1; we1 = 1; addr1 = 32'h200; wdata1 = 32'h55;
        next_cycle();
        req0 = 1; we0 = 0; addr0 = 32'h200;
        @(negedge clock);
        total++;
        if ({gnt1, gnt0, mem_we, mem_re, mem_addr, mem_din} !== {4'b1010, 32'h200, 32'h55}) begin
            bad++; $display("FAIL write_beat: got %b %h %h want 1010 200 55",
                            {gnt1, gnt0, mem_we, mem_re}, mem_addr, mem_din);
        end
        next_cycle();
        req1 = 0;
        @(negedge clock);
        total++;
        if ({gnt0, mem_re, mem_we, rvalid0, rvalid1, mem_addr} !== {5'b11000, 32'h200}) begin
            bad++; $display("FAIL read_after_write: got %b %h want 11000 200",
                            {gnt0, mem_re, mem_we, rvalid0, rvalid1}, mem_addr);
        end
        next_cycle();
        req0 = 0;
        mem_dout = 32'h55;
        @(negedge clock);
        total++;
        if ({rvalid0, rvalid1, mem_we, rdata0} !== {3'b100, 32'h55}) begin
            bad++; $display("FAIL read_after_write_ret: got %b %h want 100 55",
                            {rvalid0, rvalid1, mem_we}, rdata0);
        end
    endtask

    // Model: owner 0 none / 1 port0 / 2 port1, pref = port favoured on contention.
    task automatic test_random(input int n);
        int  m_owner, m_pref, m_beats, served;
        bit  rv_pend, rv_tag, e_g0, e_g1, beat, wsel, prev_g0, prev_g1;
        logic [31:0] e_addr, e_din, e_rd0, e_rd1;
        logic [2:0]  e_op;
        do_reset();
        m_owner = 0; m_pref = 0; m_beats = 0; rv_pend = 0; rv_tag = 0;
        prev_g0 = 0; prev_g1 = 0;
        for (int i = 0; i < n; i++) begin
            if (!req0 || prev_g0) begin
                req0 = ($urandom_range(0, 9) < 6); lock0 = 1'($urandom_range(0, 1));
                we0 = 1'($urandom_range(0, 1)); addr0 = $urandom; wdata0 = $urandom;
                op0 = 3'($urandom_range(0, 7));
            end
            if (!req1 || prev_g1) begin
                req1 = ($urandom_range(0, 9) < 6); lock1 = ($urandom_range(0, 9) < 7);
                we1 = 1'($urandom_range(0, 1)); addr1 = $urandom; wdata1 = $urandom;
                op1 = 3'($urandom_range(0, 7));
            end
            mem_dout = $urandom;
            @(negedge clock);
            e_g0 = (m_owner == 1) && req0;
            e_g1 = (m_owner == 2) && req1;
            beat = e_g0 || e_g1;
            wsel = e_g1 ? we1 : we0;
            total++;
            if ({gnt0, gnt1, owner} !== {e_g0, e_g1, 2'(m_owner)}) begin
                bad++; $display("FAIL rand_grant[%0d]: got %b want %b", i, {gnt0, gnt1, owner},
                                {e_g0, e_g1, 2'(m_owner)});
            end
            total++;
            if ({mem_we, mem_re} !== {beat && wsel, beat && !wsel}) begin
                bad++; $display("FAIL rand_strobe[%0d]: got %b want %b", i, {mem_we, mem_re},
                                {beat && wsel, beat && !wsel});
            end
            if (beat) begin
                e_addr = e_g1 ? addr1 : addr0;
                e_din  = e_g1 ? wdata1 : wdata0;
                e_op   = e_g1 ? op1 : op0;
                total++;
                if ({mem_addr, mem_din, mem_op} !== {e_addr, e_din, e_op}) begin
                    bad++; $display("FAIL rand_mux[%0d]: got %h %h %h want %h %h %h", i,
                                    mem_addr, mem_din, mem_op, e_addr, e_din, e_op);
                end
            end
            e_rd0 = (rv_pend && !rv_tag) ? mem_dout : 32'h0;
            e_rd1 = (rv_pend && rv_tag) ? mem_dout : 32'h0;
            total++;
            if ({rvalid0, rvalid1, rdata0, rdata1} !==
                {rv_pend && !rv_tag, rv_pend && rv_tag, e_rd0, e_rd1}) begin
                bad++; $display("FAIL rand_return[%0d]: got %b %h %h want %b %h %h", i,
                                {rvalid0, rvalid1}, rdata0, rdata1,
                                {rv_pend && !rv_tag, rv_pend && rv_tag}, e_rd0, e_rd1);
            end
            rv_pend = beat && !wsel;
            rv_tag  = e_g1;
            if (beat) begin
                served = e_g1 ? 1 : 0;
                m_pref = 1 - served;
                m_beats++;
            end
            if (!(beat && (e_g1 ? lock1 : lock0) && m_beats < MAXB)) begin
                m_beats = 0;
                if (req0 && req1) m_owner = m_pref + 1;
                else if (req0)    m_owner = 1;
                else if (req1)    m_owner = 2;
                else              m_owner = 0;
            end
            prev_g0 = e_g0;
            prev_g1 = e_g1;
            next_cycle();
        end
    endtask

`ifdef DMEM_ARB_STATS_EN
    task automatic test_stats();
        do_reset();
        req0 = 1; lock0 = 1; req1 = 1;
        repeat (4) next_cycle();           // idle cycle + 3 locked port-0 beats
        req0 = 0;                          // port 0 forfeits, port 1 still waiting
        next_cycle();
        req1 = 0;
        next_cycle();
        total++;
        if ({stat_beats0, stat_beats1, stat_wait1} !== {32'd3, 32'd0, 32'd5}) begin
            bad++; $display("FAIL stats_count: got %0d %0d %0d want 3 0 5",
                            stat_beats0, stat_beats1, stat_wait1);
        end
        stat_clr = 1; req1 = 1;
        next_cycle();
        stat_clr = 0; req1 = 0;
        total++;
        if ({stat_beats0, stat_beats1, stat_wait1} !== 96'd0) begin
            bad++; $display("FAIL stats_clear: got %0d %0d %0d want 0 0 0",
                            stat_beats0, stat_beats1, stat_wait1);
        end
    endtask
`endif

    initial begin
        reset = 1;
        clear_inputs();
        test_reset();
        test_single_read();
        test_round_robin();
        test_lock_burst();
        test_write_then_read();
        test_random(600);
`ifdef DMEM_ARB_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
